// File: rtl/fpu_master.sv
// rtl/fpu_master.sv - request FIFO plus single-outstanding FPU handshake master with timeout
module fpu_master #(
    parameter int bitness = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [bitness-1:0] req_a,
    input  logic [bitness-1:0] req_b,
    input  logic [3:0]         req_cmd,
    output logic               fpu_input_rdy,
    input  logic               fpu_input_ack,
    output logic [bitness-1:0] fpu_data_a,
    output logic [bitness-1:0] fpu_data_b,
    output logic [3:0]         fpu_command,
    input  logic               fpu_output_rdy,
    output logic               fpu_output_ack,
    input  logic [bitness-1:0] fpu_result,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [bitness-1:0] rsp_result,
    output logic               rsp_error,
    output logic [7:0]         issued_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 2 * bitness + 4;
    localparam logic [CW-1:0] FULL    = CW'(DEPTH);
    localparam logic [15:0]   TMO_MAX = 16'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

    state_t             r_state;
    logic [EW-1:0]      r_mem [DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [CW-1:0]      r_count;
    logic               r_nonempty_d;
    logic [15:0]        r_tmo;
    logic               r_input_rdy;
    logic               r_output_ack;
    logic               r_rsp_valid;
    logic               r_rsp_error;
    logic [bitness-1:0] r_data_a;
    logic [bitness-1:0] r_data_b;
    logic [bitness-1:0] r_rsp_result;
    logic [3:0]         r_command;
    logic [7:0]         r_issued;

    logic               w_push;
    logic               w_pop;
    logic               w_tmo_hit;
    logic [15:0]        w_tmo_next;
    logic [EW-1:0]      w_head;

    assign req_ready  = (r_count < FULL);
    assign w_push     = req_valid && req_ready;
    assign w_head     = r_mem[r_rd_ptr];
    assign w_tmo_next = (r_tmo >= TMO_MAX) ? TMO_MAX : r_tmo + 16'd1;
    assign w_tmo_hit  = (w_tmo_next == TMO_MAX);
    // The head leaves on an operand ack, or when an ISSUE timeout can actually be reported.
    assign w_pop      = (r_state == ISSUE) && (fpu_input_ack || (w_tmo_hit && !r_rsp_valid));

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {req_a, req_b, req_cmd};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_nonempty_d <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push && !w_pop)      r_count <= r_count + CW'(1);
            else if (!w_push && w_pop) r_count <= r_count - CW'(1);
            // Occupancy reaches the FSM through one register stage, giving a two-edge issue latency.
            r_nonempty_d <= (r_count != '0);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= IDLE;
            r_tmo        <= '0;
            r_input_rdy  <= 1'b0;
            r_output_ack <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_error  <= 1'b0;
            r_rsp_result <= '0;
            r_data_a     <= '0;
            r_data_b     <= '0;
            r_command    <= '0;
            r_issued     <= '0;
        end else begin
            if (r_rsp_valid && rsp_ready) r_rsp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (r_nonempty_d && (r_count != '0)) begin
                        {r_data_a, r_data_b, r_command} <= w_head;
                        r_input_rdy <= 1'b1;
                        r_tmo       <= '0;
                        r_state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_tmo <= w_tmo_next;
                    if (fpu_input_ack) begin
                        r_input_rdy <= 1'b0;
                        r_state     <= WAIT;
                    end else if (w_tmo_hit && !r_rsp_valid) begin
                        r_input_rdy  <= 1'b0;
                        r_rsp_valid  <= 1'b1;
                        r_rsp_error  <= 1'b1;
                        r_rsp_result <= '0;
                        r_issued     <= r_issued + 8'd1;
                        r_state      <= IDLE;
                    end
                end
                WAIT: begin
                    if (fpu_output_rdy) begin
                        // A held response stalls the result without consuming timeout budget.
                        if (!r_rsp_valid) begin
                            r_output_ack <= 1'b1;
                            r_rsp_result <= fpu_result;
                            r_rsp_error  <= 1'b0;
                            r_rsp_valid  <= 1'b1;
                            r_issued     <= r_issued + 8'd1;
                            r_state      <= ACK;
                        end
                    end else begin
                        r_tmo <= w_tmo_next;
                        if (w_tmo_hit && !r_rsp_valid) begin
                            r_rsp_valid  <= 1'b1;
                            r_rsp_error  <= 1'b1;
                            r_rsp_result <= '0;
                            r_issued     <= r_issued + 8'd1;
                            r_state      <= IDLE;
                        end
                    end
                end
                ACK: begin
                    r_output_ack <= 1'b0;
                    r_state      <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign fpu_input_rdy  = r_input_rdy;
    assign fpu_data_a     = r_data_a;
    assign fpu_data_b     = r_data_b;
    assign fpu_command    = r_command;
    assign fpu_output_ack = r_output_ack;
    assign rsp_valid      = r_rsp_valid;
    assign rsp_result     = r_rsp_result;
    assign rsp_error      = r_rsp_error;
    assign issued_count   = r_issued;
endmodule

// File: tb/tb_fpu_master.sv
// tb/tb_fpu_master.sv - directed vector bench for fpu_master with a scripted FPU model
module tb_fpu_master;
    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a, req_b;
    logic [3:0]  req_cmd;
    logic        fpu_input_rdy, fpu_input_ack;
    logic [31:0] fpu_data_a, fpu_data_b;
    logic [3:0]  fpu_command;
    logic        fpu_output_rdy, fpu_output_ack;
    logic [31:0] fpu_result;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_error;
    logic [7:0]  issued_count;

    fpu_master #(.bitness(32), .DEPTH(4), .TIMEOUT(16)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_cmd(req_cmd),
        .fpu_input_rdy(fpu_input_rdy), .fpu_input_ack(fpu_input_ack),
        .fpu_data_a(fpu_data_a), .fpu_data_b(fpu_data_b), .fpu_command(fpu_command),
        .fpu_output_rdy(fpu_output_rdy), .fpu_output_ack(fpu_output_ack),
        .fpu_result(fpu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_error(rsp_error),
        .issued_count(issued_count)
    );

    always #5 clock = ~clock;

    typedef struct { logic [31:0] a; logic [31:0] b; logic [3:0] cmd; } op_t;
    typedef struct { logic [31:0] res; logic err; } rsp_t;
    typedef struct {
        logic [31:0] a; logic [31:0] b; logic [3:0] cmd; logic [31:0] fres;
        int ack_d; int res_d; logic [7:0] exp_issued;
    } vec_t;

    op_t         exp_ops[$];
    rsp_t        exp_rsp[$];
    logic [31:0] res_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int ack_dly = 1;
    int res_dly = 1;
    int ack_pulses = 0;
    int fst = 0;
    int fcnt = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scripted FPU: acks operands after ack_dly cycles, offers the next queued result res_dly cycles later.
    initial begin
        op_t e;
        fpu_input_ack = 1'b0; fpu_output_rdy = 1'b0; fpu_result = '0;
        forever begin
            @(negedge clock);
            if (reset) begin
                fpu_input_ack = 1'b0; fpu_output_rdy = 1'b0; fst = 0;
            end else begin
                case (fst)
                    0: if (fpu_input_rdy) begin
                        if (exp_ops.size() == 0) begin
                            n_cmp++; n_bad++;
                            $display("FAIL op_unexpected: got issue of %0h expected none", fpu_data_a);
                        end else begin
                            e = exp_ops.pop_front();
                            chk("op_a", fpu_data_a, e.a);
                            chk("op_b", fpu_data_b, e.b);
                            chk("op_cmd", 32'(fpu_command), 32'(e.cmd));
                        end
                        fcnt = 0; fst = 1;
                    end
                    1: if (!fpu_input_rdy) fst = 0;
                    else begin
                        fcnt++;
                        if (fcnt >= ack_dly) begin fpu_input_ack = 1'b1; fcnt = 0; fst = 2; end
                    end
                    2: begin
                        fpu_input_ack = 1'b0;
                        fcnt++;
                        if (fcnt >= res_dly) begin
                            fpu_output_rdy = 1'b1;
                            fpu_result = (res_q.size() != 0) ? res_q.pop_front() : 32'hDEAD_BEEF;
                            fst = 3;
                        end
                    end
                    default: if (fpu_output_ack) begin fpu_output_rdy = 1'b0; fst = 0; end
                endcase
            end
        end
    end

    initial begin
        rsp_t e;
        forever begin
            @(negedge clock); #1;
            if (!reset && rsp_valid && rsp_ready) begin
                if (exp_rsp.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL rsp_unexpected: got %0h expected none", rsp_result);
                end else begin
                    e = exp_rsp.pop_front();
                    chk("rsp_result", rsp_result, e.res);
                    chk("rsp_error", 32'(rsp_error), 32'(e.err));
                end
            end
        end
    end

    initial begin
        logic prev_ack = 1'b0;
        forever begin
            @(negedge clock); #1;
            if (prev_ack) chk("ack_one_cycle", 32'(fpu_output_ack), 0);
            else if (fpu_output_ack) ack_pulses++;
            prev_ack = fpu_output_ack;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
        int n = 0;
        req_a = a; req_b = b; req_cmd = c; req_valid = 1'b1;
        while (!req_ready && n < 200) begin @(negedge clock); n++; end
        @(negedge clock);
        req_valid = 1'b0;
        chk("push_accept", 32'(n < 200), 1);
    endtask

    task automatic expect_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c,
                             input logic [31:0] r, input logic err);
        exp_ops.push_back('{a: a, b: b, cmd: c});
        if (!err) res_q.push_back(r);
        exp_rsp.push_back('{res: err ? 32'h0 : r, err: err});
    endtask

    task automatic txn(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c,
                       input logic [31:0] r, input logic err);
        expect_op(a, b, c, r, err);
        push(a, b, c);
    endtask

    task automatic wait_drain(input int limit);
        int n = 0;
        while (exp_rsp.size() != 0 && n < limit) begin @(negedge clock); n++; end
        chk("drain_in_time", 32'(n < limit), 1);
        repeat (3) @(negedge clock);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 1);
        chk({tag, "_input_rdy"}, 32'(fpu_input_rdy), 0);
        chk({tag, "_output_ack"}, 32'(fpu_output_ack), 0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
        chk({tag, "_rsp_error"}, 32'(rsp_error), 0);
        chk({tag, "_rsp_result"}, rsp_result, 0);
        chk({tag, "_data_a"}, fpu_data_a, 0);
        chk({tag, "_data_b"}, fpu_data_b, 0);
        chk({tag, "_command"}, 32'(fpu_command), 0);
        chk({tag, "_issued"}, 32'(issued_count), 0);
    endtask

    initial begin
        vec_t vecs[5];
        int   n, t0, p0;
        logic bad;

        vecs[0] = '{32'h0000_0000, 32'h0000_0000, 4'h1, 32'h0000_0000, 1, 1, 8'd2};
        vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 4'hF, 32'hFFFF_FFFF, 2, 3, 8'd3};
        vecs[2] = '{32'h7F80_0000, 32'hFF80_0000, 4'h5, 32'h7FC0_0000, 5, 5, 8'd4};
        vecs[3] = '{32'hA5A5_A5A5, 32'h5A5A_5A5A, 4'hA, 32'h1234_5678, 1, 8, 8'd5};
        vecs[4] = '{32'h8000_0000, 32'h0000_0000, 4'h3, 32'h8000_0001, 8, 3, 8'd6};

        reset = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_cmd = '0; rsp_ready = 1'b1;
        repeat (2) @(negedge clock);
        check_reset_vals("rst");
        reset = 1'b0;
        @(negedge clock);

        // Single op: 1.0 + 2.0 -> 3.0, also issue latency from accept edge.
        ack_dly = 3; res_dly = 10; p0 = ack_pulses;
        txn(32'h3F80_0000, 32'h4000_0000, 4'h0, 32'h4040_0000, 1'b0);
        t0 = cyc; n = 0;
        while (!fpu_input_rdy && n < 10) begin @(negedge clock); n++; end
        chk("issue_latency", cyc - t0, 2);
        wait_drain(100);
        chk("single_ack_pulses", ack_pulses - p0, 1);
        chk("single_issued", 32'(issued_count), 1);

        for (int i = 0; i < 5; i++) begin
            ack_dly = vecs[i].ack_d; res_dly = vecs[i].res_d;
            txn(vecs[i].a, vecs[i].b, vecs[i].cmd, vecs[i].fres, 1'b0);
            wait_drain(100);
            chk($sformatf("vec%0d_issued", i), 32'(issued_count), 32'(vecs[i].exp_issued));
        end

        // Fill: operand ack held off long enough for the FIFO to fill.
        ack_dly = 12; res_dly = 1;
        for (int i = 0; i < 4; i++) txn(32'h100 + i, 32'h200 + i, 4'(i), 32'h1001 + i, 1'b0);
        chk("fill_ready_low", 32'(req_ready), 0);
        expect_op(32'h104, 32'h204, 4'h4, 32'h1005, 1'b0);
        req_a = 32'h104; req_b = 32'h204; req_cmd = 4'h4; req_valid = 1'b1;
        repeat (3) @(negedge clock);
        chk("fill_fifth_waits", 32'(req_ready), 0);
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clock); n++; end
        @(negedge clock);
        req_valid = 1'b0;
        chk("fill_fifth_accepted", 32'(n < 50), 1);
        wait_drain(400);
        chk("fill_issued", 32'(issued_count), 11);

        // Backpressure: second result offered while first response is held.
        rsp_ready = 1'b0; ack_dly = 1; res_dly = 1;
        txn(32'hA0, 32'hA1, 4'h2, 32'hAAAA_0001, 1'b0);
        txn(32'hB0, 32'hB1, 4'h6, 32'hBBBB_0002, 1'b0);
        n = 0;
        while (!fpu_output_rdy || !rsp_valid || fpu_output_ack) begin
            if (n >= 60) break;
            @(negedge clock); n++;
        end
        chk("bp_stall_reached", 32'(n < 60), 1);
        p0 = ack_pulses; bad = 1'b0;
        repeat (40) begin
            @(negedge clock);
            if (fpu_output_ack || rsp_error) bad = 1'b1;
        end
        chk("bp_no_ack_no_timeout", 32'(bad), 0);
        chk("bp_result_held", rsp_result, 32'hAAAA_0001);
        rsp_ready = 1'b1;
        wait_drain(100);
        chk("bp_ack_after_release", ack_pulses - p0, 1);
        chk("bp_issued", 32'(issued_count), 13);

        // Timeout in ISSUE: FPU never takes the operands.
        ack_dly = 100000;
        txn(32'h1111_2222, 32'h3333_4444, 4'h7, 32'h0, 1'b1);
        n = 0;
        while (!fpu_input_rdy && n < 10) begin @(negedge clock); n++; end
        t0 = cyc; n = 0;
        while (!rsp_valid && n < 40) begin @(negedge clock); n++; end
        chk("tmo_cycles", cyc - t0, 16);
        chk("tmo_input_rdy_low", 32'(fpu_input_rdy), 0);
        wait_drain(50);
        repeat (5) @(negedge clock);
        chk("tmo_entry_popped", 32'(fpu_input_rdy), 0);
        chk("tmo_issued", 32'(issued_count), 14);

        // Reset while in WAIT with two requests still queued.
        ack_dly = 1; res_dly = 30;
        for (int i = 0; i < 3; i++) txn(32'hC0 + i, 32'hD0 + i, 4'h9, 32'hE0 + i, 1'b0);
        n = 0;
        while (!fpu_input_rdy && n < 10) begin @(negedge clock); n++; end
        while (fpu_input_rdy && n < 20) begin @(negedge clock); n++; end
        chk("rmid_in_wait", 32'(fst), 2);
        reset = 1'b1;
        @(negedge clock);
        check_reset_vals("rmid");
        @(negedge clock);
        reset = 1'b0;
        exp_ops.delete(); exp_rsp.delete(); res_q.delete();
        bad = 1'b0;
        repeat (20) begin
            @(negedge clock);
            if (rsp_valid || fpu_input_rdy) bad = 1'b1;
        end
        chk("rmid_nothing_after", 32'(bad), 0);

        // issued_count wraps after 256 completions.
        ack_dly = 1; res_dly = 1;
        for (int i = 0; i < 255; i++) txn(32'(i), ~32'(i), 4'(i), 32'h5000_0000 + i, 1'b0);
        wait_drain(200);
        chk("wrap_255", 32'(issued_count), 255);
        txn(32'h0F0F_0F0F, 32'hF0F0_F0F0, 4'hE, 32'h6000_0000, 1'b0);
        wait_drain(100);
        chk("wrap_0", 32'(issued_count), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
